// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR tap feeder: sequencer states,
// default tap geometry and the output saturation helper.
package fir_pkg;

    localparam int NUM_TAPS    = 64;
    localparam int MAC_LATENCY = 4;
    localparam int OUT_SHIFT   = 6;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        WRITE,
        RUN,
        DRAIN,
        CAPTURE
    } fir_state_e;

    // Clamp a signed value to the range of a w-bit signed number; the caller
    // truncates the result to w bits.
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fir_tap_feeder_if.sv
// Coefficient/data/enable link between the tap feeder (master) and the FIR MAC
// tap (slave), plus the accumulated result coming back.
interface fir_tap_if #(
    parameter int COEF_W = 16,
    parameter int DATA_W = 24,
    parameter int ACC_W  = 32
);
    logic [COEF_W-1:0] tap_coefficients;
    logic [DATA_W-1:0] tap_aud_data;
    logic              tap_data_en;
    logic              tap_accum_clr;
    logic [ACC_W-1:0]  tap_result_in;

    modport master (
        output tap_coefficients, tap_aud_data, tap_data_en, tap_accum_clr,
        input  tap_result_in
    );

    modport slave (
        input  tap_coefficients, tap_aud_data, tap_data_en, tap_accum_clr,
        output tap_result_in
    );
endinterface

// File: rtl/fir_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (latency 1).
// A same-address write and read in one cycle returns the old contents.
module fir_sdp_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 24
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/fir_tap_feeder.sv
// Per input sample: write it into the circular delay line, stream NUM_TAPS
// (coef, delayed sample) pairs into the MAC tap, then scale/saturate its result.
module fir_tap_feeder #(
    parameter int NUM_TAPS    = fir_pkg::NUM_TAPS,
    parameter int ADDR_W      = $clog2(NUM_TAPS),
    parameter int DATA_W      = 24,
    parameter int COEF_W      = 16,
    parameter int ACC_W       = 32,
    parameter int MAC_LATENCY = fir_pkg::MAC_LATENCY,
    parameter int OUT_SHIFT   = fir_pkg::OUT_SHIFT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              audio_en,
    input  logic [DATA_W-1:0] aud_data_in,
    input  logic              coef_wr_en,
    input  logic [ADDR_W-1:0] coef_wr_addr,
    input  logic [COEF_W-1:0] coef_wr_data,
    fir_tap_if.master         tap,
    output logic [DATA_W-1:0] audio_out,
    output logic              audio_out_valid,
    output logic              busy,
    output logic              sample_overrun
);
    import fir_pkg::*;

    localparam int                DCNT_W     = $clog2(MAC_LATENCY + 1) + 1;
    localparam logic [ADDR_W-1:0] CNT_LAST   = ADDR_W'(NUM_TAPS - 1);
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(MAC_LATENCY);

    fir_state_e        state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [DCNT_W-1:0] dcnt;
    logic [DATA_W-1:0] sample_q;
    logic              tap_en_q;

    logic              dl_we;
    logic [ADDR_W-1:0] dl_waddr;
    logic [DATA_W-1:0] dl_wdata;
    logic [ADDR_W-1:0] dl_raddr;
    logic [DATA_W-1:0] dl_rdata;
    logic [COEF_W-1:0] cf_rdata;
    logic              rd_en;
    logic              capture;

    logic signed [63:0] res_ext;
    logic [DATA_W-1:0]  res_sat;

    always_ff @(posedge clk) begin
        if (reset_n) state <= CLEAR;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        dl_we     = 1'b0;
        dl_waddr  = cnt;
        dl_wdata  = '0;
        rd_en     = 1'b0;
        capture   = 1'b0;
        case (state)
            CLEAR: begin
                dl_we = 1'b1;
                if (cnt == CNT_LAST) state_nxt = IDLE;
            end
            IDLE:    if (audio_en) state_nxt = WRITE;
            WRITE: begin
                dl_we     = 1'b1;
                dl_waddr  = wr_ptr;
                dl_wdata  = sample_q;
                state_nxt = RUN;
            end
            RUN: begin
                rd_en = 1'b1;
                if (cnt == CNT_LAST) state_nxt = DRAIN;
            end
            // Result is sampled on the last drain cycle so audio_out is
            // already valid while the state reads CAPTURE.
            DRAIN: begin
                if (dcnt == DRAIN_LAST) begin
                    capture   = 1'b1;
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            cnt             <= '0;
            dcnt            <= '0;
            wr_ptr          <= '0;
            sample_q        <= '0;
            tap_en_q        <= 1'b0;
            audio_out       <= '0;
            audio_out_valid <= 1'b0;
            sample_overrun  <= 1'b0;
        end else begin
            cnt             <= (state == CLEAR || state == RUN) ? cnt + 1'b1 : '0;
            dcnt            <= (state == DRAIN) ? dcnt + 1'b1 : '0;
            tap_en_q        <= rd_en;
            audio_out_valid <= capture;
            if (capture) audio_out <= res_sat;
            if (state == IDLE && audio_en) sample_q <= aud_data_in;
            if (state == CAPTURE) wr_ptr <= wr_ptr + 1'b1;
            if (audio_en && state != IDLE) sample_overrun <= 1'b1;
        end
    end

    // Tap k pairs coef[k] with x[n-k]; the subtraction wraps in ADDR_W bits.
    assign dl_raddr = wr_ptr - cnt;

    fir_sdp_ram #(.DEPTH(NUM_TAPS), .AW(ADDR_W), .DW(DATA_W)) u_delay (
        .clk   (clk),
        .we    (dl_we),
        .waddr (dl_waddr),
        .wdata (dl_wdata),
        .re    (rd_en),
        .raddr (dl_raddr),
        .rdata (dl_rdata)
    );

    fir_sdp_ram #(.DEPTH(NUM_TAPS), .AW(ADDR_W), .DW(COEF_W)) u_coef (
        .clk   (clk),
        .we    (coef_wr_en),
        .waddr (coef_wr_addr),
        .wdata (coef_wr_data),
        .re    (rd_en),
        .raddr (cnt),
        .rdata (cf_rdata)
    );

    assign res_ext = $signed({{(64 - ACC_W){tap.tap_result_in[ACC_W-1]}}, tap.tap_result_in}) >>> OUT_SHIFT;
    assign res_sat = DATA_W'(sat_to_width(res_ext, DATA_W));

    assign tap.tap_data_en      = tap_en_q;
    assign tap.tap_accum_clr    = (state == WRITE);
    assign tap.tap_coefficients = tap_en_q ? cf_rdata : '0;
    assign tap.tap_aud_data     = tap_en_q ? dl_rdata : '0;
    assign busy                 = (state != IDLE) && !reset_n;
endmodule

// File: tb/tb_fir_tap_feeder.sv
// Directed bench for fir_tap_feeder: a passive tap model records the streamed
// pairs and returns a fixed accumulator value for each sample.
module tb_fir_tap_feeder;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        audio_en = 1'b0;
    logic [23:0] aud_data_in = '0;
    logic        coef_wr_en = 1'b0;
    logic [5:0]  coef_wr_addr = '0;
    logic [15:0] coef_wr_data = '0;
    logic [23:0] audio_out;
    logic        audio_out_valid;
    logic        busy;
    logic        sample_overrun;

    fir_tap_if #(.COEF_W(16), .DATA_W(24), .ACC_W(32)) tap ();

    fir_tap_feeder dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .audio_en        (audio_en),
        .aud_data_in     (aud_data_in),
        .coef_wr_en      (coef_wr_en),
        .coef_wr_addr    (coef_wr_addr),
        .coef_wr_data    (coef_wr_data),
        .tap             (tap),
        .audio_out       (audio_out),
        .audio_out_valid (audio_out_valid),
        .busy            (busy),
        .sample_overrun  (sample_overrun)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] cap_coef [64];
    logic [23:0] cap_data [64];
    int          n_en, clr_cyc, first_en, valid_cyc, n_valid;
    logic [23:0] out_val, out_end;

    // Cycle T = the negedge where audio_en is raised; c counts cycles after T.
    task automatic run_sample(input logic [23:0] s, input logic [31:0] res,
                              input int extra_at, input int rst_at);
        n_en = 0; clr_cyc = -1; first_en = -1; valid_cyc = -1; n_valid = 0;
        out_val = '0;
        @(negedge clk);
        tap.tap_result_in = res;
        aud_data_in = s;
        audio_en = 1'b1;
        for (int c = 1; c <= 75; c++) begin
            @(negedge clk);
            audio_en = 1'b0;
            if (tap.tap_accum_clr && clr_cyc < 0) clr_cyc = c;
            if (tap.tap_data_en) begin
                if (n_en == 0) first_en = c;
                if (n_en < 64) begin
                    cap_coef[n_en] = tap.tap_coefficients;
                    cap_data[n_en] = tap.tap_aud_data;
                end
                n_en++;
            end
            if (audio_out_valid) begin
                n_valid++;
                valid_cyc = c;
                out_val = audio_out;
            end
            if (c == extra_at) begin
                audio_en = 1'b1;
                aud_data_in = 24'hBADBAD;
            end
            if (c == rst_at) reset_n = 1'b1;
            if (c == rst_at + 2) reset_n = 1'b0;
        end
        out_end = audio_out;
    endtask

    task automatic apply_reset(output int busy_cycles);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        busy_cycles = 0;
        #1;
        for (int k = 0; k < 300 && busy; k++) begin
            busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, k); end
    endtask

    task automatic test_reset();
        int bc;
        tap.tap_result_in = '0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_checks++; if (audio_out !== 24'h0) begin n_fail++; $display("FAIL rst_audio_out: got %h expected 000000", audio_out); end
        n_checks++; if (audio_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", audio_out_valid); end
        n_checks++; if (sample_overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b expected 0", sample_overrun); end
        n_checks++; if (tap.tap_data_en !== 1'b0 || tap.tap_accum_clr !== 1'b0) begin n_fail++; $display("FAIL rst_tap_ctl: got en=%b clr=%b expected 0/0", tap.tap_data_en, tap.tap_accum_clr); end
        n_checks++; if (tap.tap_coefficients !== 16'h0 || tap.tap_aud_data !== 24'h0) begin n_fail++; $display("FAIL rst_tap_bus: got %h/%h expected 0/0", tap.tap_coefficients, tap.tap_aud_data); end
        reset_n = 1'b0;
        bc = 0;
        #1;
        for (int k = 0; k < 300 && busy; k++) begin
            bc++;
            @(negedge clk);
        end
        n_checks++; if (bc !== 64) begin n_fail++; $display("FAIL clear_busy_cycles: got %0d expected 64", bc); end
    endtask

    task automatic test_first_sample();
        int nz;
        run_sample(24'h123456, 32'h0000_4840, -5, -5);
        nz = 0;
        for (int k = 1; k < 64; k++) if (cap_data[k] !== 24'h0) nz++;
        n_checks++; if (n_en !== 64) begin n_fail++; $display("FAIL first_n_en: got %0d expected 64", n_en); end
        n_checks++; if (cap_data[0] !== 24'h123456) begin n_fail++; $display("FAIL first_tap0_data: got %h expected 123456", cap_data[0]); end
        n_checks++; if (nz !== 0) begin n_fail++; $display("FAIL first_zero_taps: got %0d nonzero expected 0", nz); end
        n_checks++; if (clr_cyc !== 1) begin n_fail++; $display("FAIL first_clr_cycle: got %0d expected 1", clr_cyc); end
        n_checks++; if (first_en !== 3) begin n_fail++; $display("FAIL first_en_cycle: got %0d expected 3", first_en); end
        n_checks++; if (valid_cyc !== 71 || n_valid !== 1) begin n_fail++; $display("FAIL first_latency: got cycle %0d count %0d expected 71/1", valid_cyc, n_valid); end
        n_checks++; if (out_val !== 24'h000121) begin n_fail++; $display("FAIL first_audio_out: got %h expected 000121", out_val); end
        n_checks++; if (out_end !== 24'h000121) begin n_fail++; $display("FAIL first_out_hold: got %h expected 000121", out_end); end
    endtask

    task automatic test_coef_pairs();
        int bc, bad;
        apply_reset(bc);
        n_checks++; if (bc !== 64) begin n_fail++; $display("FAIL reclear_busy_cycles: got %0d expected 64", bc); end
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            coef_wr_en = 1'b1;
            coef_wr_addr = 6'(k);
            coef_wr_data = 16'(k);
        end
        @(negedge clk);
        coef_wr_en = 1'b0;
        run_sample(24'h000001, 32'h0000_4840, -5, -5);
        run_sample(24'h000002, 32'h0000_4840, -5, -5);
        bad = 0;
        for (int k = 0; k < 64; k++) if (cap_coef[k] !== 16'(k)) bad++;
        n_checks++; if (cap_coef[0] !== 16'd0 || cap_data[0] !== 24'h2) begin n_fail++; $display("FAIL pair0: got (%h,%h) expected (0000,000002)", cap_coef[0], cap_data[0]); end
        n_checks++; if (cap_coef[1] !== 16'd1 || cap_data[1] !== 24'h1) begin n_fail++; $display("FAIL pair1: got (%h,%h) expected (0001,000001)", cap_coef[1], cap_data[1]); end
        n_checks++; if (cap_coef[2] !== 16'd2 || cap_data[2] !== 24'h0) begin n_fail++; $display("FAIL pair2: got (%h,%h) expected (0002,000000)", cap_coef[2], cap_data[2]); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL coef_ramp: got %0d wrong coefficients expected 0", bad); end
        n_checks++; if (n_en !== 64) begin n_fail++; $display("FAIL pairs_n_en: got %0d expected 64", n_en); end
        n_checks++; if (first_en - clr_cyc !== 2) begin n_fail++; $display("FAIL clr_lead: got %0d expected 2", first_en - clr_cyc); end
    endtask

    task automatic test_wrap();
        int bad;
        for (int i = 3; i <= 65; i++) run_sample(24'(i), 32'h0000_4840, -5, -5);
        bad = 0;
        for (int k = 0; k < 64; k++) if (cap_data[k] !== 24'(65 - k)) bad++;
        n_checks++; if (cap_data[0] !== 24'd65) begin n_fail++; $display("FAIL wrap_tap0: got %h expected 000041", cap_data[0]); end
        n_checks++; if (cap_data[1] !== 24'd64) begin n_fail++; $display("FAIL wrap_tap1: got %h expected 000040", cap_data[1]); end
        n_checks++; if (cap_data[63] !== 24'd2) begin n_fail++; $display("FAIL wrap_tap63: got %h expected 000002", cap_data[63]); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL wrap_all_taps: got %0d wrong taps expected 0", bad); end
        n_checks++; if (out_val !== 24'h000121 || valid_cyc !== 71) begin n_fail++; $display("FAIL wrap_output: got %h at %0d expected 000121 at 71", out_val, valid_cyc); end
    endtask

    task automatic test_saturation();
        logic [31:0] res_tab [5] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFC0, 32'h1FFF_FFC0, 32'hE000_0000};
        logic [23:0] exp_tab [5] = '{24'h7FFFFF,    24'h800000,    24'hFFFFFF,    24'h7FFFFF,    24'h800000};
        for (int i = 0; i < 5; i++) begin
            run_sample(24'(i + 7), res_tab[i], -5, -5);
            n_checks++; if (out_val !== exp_tab[i] || n_valid !== 1) begin n_fail++; $display("FAIL sat_%0d: got %h (valid count %0d) expected %h", i, out_val, n_valid, exp_tab[i]); end
        end
    endtask

    task automatic test_overrun();
        n_checks++; if (sample_overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_pre: got %b expected 0", sample_overrun); end
        run_sample(24'h000010, 32'h0000_4840, 10, -5);
        n_checks++; if (sample_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_flag: got %b expected 1", sample_overrun); end
        n_checks++; if (n_valid !== 1 || valid_cyc !== 71) begin n_fail++; $display("FAIL overrun_one_output: got count %0d at %0d expected 1 at 71", n_valid, valid_cyc); end
        n_checks++; if (out_val !== 24'h000121) begin n_fail++; $display("FAIL overrun_out: got %h expected 000121", out_val); end
        n_checks++; if (cap_data[0] !== 24'h000010 || n_en !== 64) begin n_fail++; $display("FAIL overrun_taps: got %h/%0d expected 000010/64", cap_data[0], n_en); end
    endtask

    task automatic test_reset_midrun();
        int nz;
        run_sample(24'h000020, 32'h0000_4840, -5, 20);
        n_checks++; if (n_valid !== 0) begin n_fail++; $display("FAIL abort_no_valid: got %0d expected 0", n_valid); end
        n_checks++; if (n_en !== 18) begin n_fail++; $display("FAIL abort_enables: got %0d expected 18", n_en); end
        wait_idle();
        n_checks++; if (sample_overrun !== 1'b0) begin n_fail++; $display("FAIL abort_overrun_clr: got %b expected 0", sample_overrun); end
        run_sample(24'h000033, 32'h0000_4840, -5, -5);
        nz = 0;
        for (int k = 1; k < 64; k++) if (cap_data[k] !== 24'h0) nz++;
        n_checks++; if (cap_data[0] !== 24'h000033 || nz !== 0) begin n_fail++; $display("FAIL post_reset_taps: got %h with %0d nonzero expected 000033 with 0", cap_data[0], nz); end
        n_checks++; if (cap_coef[5] !== 16'd5) begin n_fail++; $display("FAIL coef_kept: got %h expected 0005", cap_coef[5]); end
        n_checks++; if (out_val !== 24'h000121 || valid_cyc !== 71) begin n_fail++; $display("FAIL post_reset_out: got %h at %0d expected 000121 at 71", out_val, valid_cyc); end
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_coef_pairs();
        test_wrap();
        test_saturation();
        test_overrun();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_tap_feeder.md
Name: fir_tap_feeder

Overview:
Sequencer that drives the FIR MAC tap, the producer side of its coefficient/data/enable interface. It stores incoming audio samples in a circular delay line and holds coefficients in a loadable RAM. Per input sample it streams NUM_TAPS (coefficient, delayed-sample) pairs into the tap with per-tap data enables, clears the accumulator at the start of each sample, then captures, scales and saturates the tap's accumulated result. It sits between the I2S/audio-input path and the FIR tap. Its output feeds the downstream audio path.

Parameters:
NUM_TAPS, 64, taps per output sample (power of 2)
ADDR_W, 6, log2(NUM_TAPS)
DATA_W, 24, audio sample width (signed)
COEF_W, 16, coefficient width (signed)
ACC_W, 32, width of tap result returned to this block
MAC_LATENCY, 4, cycles from last tap_data_en to a valid tap_result_in
OUT_SHIFT, 6, arithmetic right shift applied to the result before saturation

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-high reset (codebase name kept; asserted = 1)
audio_en  in  1  one-cycle strobe: aud_data_in valid
aud_data_in  in  DATA_W  new input sample
coef_wr_en  in  1  coefficient RAM write strobe
coef_wr_addr  in  ADDR_W  coefficient index
coef_wr_data  in  COEF_W  coefficient value
tap_coefficients  out  COEF_W  coefficient to tap
tap_aud_data  out  DATA_W  delayed sample to tap
tap_data_en  out  1  tap CE: pair valid this cycle
tap_accum_clr  out  1  one-cycle accumulator clear
tap_result_in  in  ACC_W  accumulated result from tap
audio_out  out  DATA_W  filtered sample
audio_out_valid  out  1  one-cycle strobe on audio_out
busy  out  1  state != IDLE
sample_overrun  out  1  sticky: audio_en arrived while busy

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset_n.
- Reset: all outputs 0, wr_ptr=0, overrun cleared, state -> CLEAR. Reset mid-operation aborts the current sample with no audio_out_valid. The coefficient RAM is not cleared.
- CLEAR: writes 0 to delay-line entries 0..NUM_TAPS-1, one per cycle, with busy=1. Then goes to IDLE.
- IDLE: audio_en at cycle T latches aud_data_in -> WRITE.
- WRITE (T+1): delay[wr_ptr] <= sample. tap_accum_clr=1 for exactly this cycle.
- RUN (T+2 .. T+1+NUM_TAPS): issues read k = 0..NUM_TAPS-1.
  - coef addr = k; delay addr = (wr_ptr - k) mod NUM_TAPS, wrapping naturally in ADDR_W bits.
  - Both RAMs have synchronous read, latency 1.
  - tap_data_en=1 at T+3+k with coef[k] and x[n-k] presented in the same cycle: NUM_TAPS consecutive enable cycles, no gaps.
  - Tap k=0 reads the sample written in WRITE.
- DRAIN: MAC_LATENCY cycles after the last enable.
- CAPTURE (T+3+NUM_TAPS+MAC_LATENCY):
  - r = tap_result_in >>> OUT_SHIFT (signed); saturated to DATA_W signed.
  - audio_out <= r; audio_out_valid=1 for one cycle; audio_out holds until the next capture.
  - wr_ptr <= wr_ptr+1 (wraps NUM_TAPS-1 -> 0); state -> IDLE.
- Sample-to-output latency = NUM_TAPS+MAC_LATENCY+3 cycles (71 at defaults). Minimum audio_en spacing = latency+1.
- audio_en while busy (including CLEAR, and the same cycle as CAPTURE): sample dropped, sample_overrun <= 1 until reset.
- Coefficient writes are accepted in any state via a dedicated RAM port. A write to address k in the same cycle as a read of k returns old data (read-first).
- tap_coefficients/tap_aud_data are don't-care when tap_data_en=0 but are driven 0 in IDLE.

Decomposition:
- Package fir_pkg holds:
  - the state enum (CLEAR, IDLE, WRITE, RUN, DRAIN, CAPTURE);
  - the saturate-to-DATA_W function;
  - the default constants NUM_TAPS, MAC_LATENCY and OUT_SHIFT.
- One sub-module, fir_sdp_ram: a parameterised simple-dual-port, read-first, 1-cycle-read RAM. It is instantiated twice, once for the delay line and once for the coefficient table.

Test Plan:
- Reset release -> busy=1 for 64 cycles, then 0. The first audio_en after CLEAR gives tap_aud_data = sample then 63 zeros on tap_data_en cycles.
- Load coef[k]=k. Send samples 0x000001, 0x000002 -> on the 2nd sample, enables 1..3 show (coef,data) = (0,0x2),(1,0x1),(2,0x0). tap_accum_clr precedes the first enable by 2 cycles. Exactly 64 enables.
- Send 65 samples -> wr_ptr wraps. On the 65th, tap k=64-1 reads sample #2, and read addresses wrap 0 -> 63.
- Bench model drives tap_result_in at capture:
  - 0x00004840 -> audio_out=0x000121, valid 71 cycles after audio_en;
  - 0x7FFFFFFF -> 0x7FFFFF;
  - 0x80000000 -> 0x800000.
- audio_en 10 cycles after a previous audio_en -> second sample ignored, sample_overrun=1, first result still produced correctly.
- reset_n asserted during RUN -> no audio_out_valid, CLEAR re-runs, and the next sample's output matches the post-reset model.
